// File: rtl/vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_alu_sequencer
// Brief    : Single-issue command sequencer for the vector element ALU.
//            Steps each instruction through register read, ALU execute and
//            register-file write-back.
// Revision : 1.0 - initial release
// ============================================================================
module vector_alu_sequencer #(
    parameter int BITS      = 8,
    parameter int NUM_VREGS = 8,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_scalar_sel,
    input  logic [BITS-1:0]  cmd_scalar,
    input  logic [IDX_W-1:0] cmd_src_a,
    input  logic [IDX_W-1:0] cmd_src_b,
    input  logic [IDX_W-1:0] cmd_dst,
    output logic [IDX_W-1:0] rf_rd_addr_a,
    output logic [IDX_W-1:0] rf_rd_addr_b,
    output logic [2:0]       alu_op_sel,
    output logic             alu_scalar_sel,
    output logic [BITS-1:0]  alu_scalar,
    output logic             alu_en,
    output logic             rf_wr_en,
    output logic [IDX_W-1:0] rf_wr_addr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    // One extra bit so NUM_VREGS == 2**IDX_W still compares correctly.
    localparam logic [IDX_W:0] c_NUM_VREGS = (IDX_W+1)'(NUM_VREGS);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_cmd_ready;
    logic             w_alu_en;
    logic             w_wr_en;
    logic             w_accept;
    logic             w_idx_legal;

    logic [2:0]       r_op;
    logic             r_scalar_sel;
    logic [BITS-1:0]  r_scalar;
    logic [IDX_W-1:0] r_src_a;
    logic [IDX_W-1:0] r_src_b;
    logic [IDX_W-1:0] r_dst;
    logic             r_err;
    logic [CNT_W-1:0] r_op_count;

    // src_b only matters when the B operand comes from the register file.
    assign w_idx_legal = ({1'b0, cmd_src_a} < c_NUM_VREGS) &&
                         ({1'b0, cmd_dst}   < c_NUM_VREGS) &&
                         (cmd_scalar_sel || ({1'b0, cmd_src_b} < c_NUM_VREGS));

    assign w_accept = cmd_valid && w_cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_alu_en     = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && w_idx_legal) begin
                    w_next_state = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_next_state = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                w_alu_en     = 1'b1;
                w_next_state = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                w_wr_en      = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Illegal commands are latched too; they are consumed, just never issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= 3'd0;
            r_scalar_sel <= 1'b0;
            r_scalar     <= '0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_dst        <= '0;
        end else if (w_accept) begin
            r_op         <= cmd_op;
            r_scalar_sel <= cmd_scalar_sel;
            r_scalar     <= cmd_scalar;
            r_src_a      <= cmd_src_a;
            r_src_b      <= cmd_src_b;
            r_dst        <= cmd_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_idx_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (r_state == c_ST_WRITE) begin
            r_op_count <= r_op_count + c_CNT_ONE;
        end
    end

    assign cmd_ready      = w_cmd_ready;
    assign busy           = (r_state != c_ST_IDLE);
    assign alu_en         = w_alu_en;
    assign rf_wr_en       = w_wr_en;
    assign done           = w_wr_en;
    assign err            = r_err;
    assign op_count       = r_op_count;
    assign rf_rd_addr_a   = r_src_a;
    assign rf_rd_addr_b   = r_src_b;
    assign rf_wr_addr     = r_dst;
    assign alu_op_sel     = r_op;
    assign alu_scalar_sel = r_scalar_sel;
    assign alu_scalar     = r_scalar;

endmodule
`default_nettype wire

// File: tb/tb_vector_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_alu_sequencer
// Brief    : Self-checking bench for vector_alu_sequencer (timeline model plus
//            directed literal expectations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_alu_sequencer;

    localparam int BITS      = 8;
    localparam int NUM_VREGS = 8;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic             cmd_scalar_sel = 1'b0;
    logic [BITS-1:0]  cmd_scalar = '0;
    logic [IDX_W-1:0] cmd_src_a = '0;
    logic [IDX_W-1:0] cmd_src_b = '0;
    logic [IDX_W-1:0] cmd_dst = '0;
    logic [IDX_W-1:0] rf_rd_addr_a;
    logic [IDX_W-1:0] rf_rd_addr_b;
    logic [2:0]       alu_op_sel;
    logic             alu_scalar_sel;
    logic [BITS-1:0]  alu_scalar;
    logic             alu_en;
    logic             rf_wr_en;
    logic [IDX_W-1:0] rf_wr_addr;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    vector_alu_sequencer #(
        .BITS(BITS), .NUM_VREGS(NUM_VREGS), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_scalar_sel(cmd_scalar_sel), .cmd_scalar(cmd_scalar),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .alu_op_sel(alu_op_sel), .alu_scalar_sel(alu_scalar_sel), .alu_scalar(alu_scalar),
        .alu_en(alu_en), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .busy(busy), .done(done), .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: m_phase counts cycles since an accepted legal command
    // (0 = idle, 1 = read, 2 = execute, 3 = write-back).
    int              m_phase = 0;
    int              m_count = 0;
    bit              m_err   = 1'b0;
    logic [2:0]      m_op    = '0;
    logic            m_ssel  = 1'b0;
    logic [BITS-1:0] m_scal  = '0;
    int              m_a = 0, m_b = 0, m_d = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_count = 0; m_err = 1'b0;
            m_op = '0; m_ssel = 1'b0; m_scal = '0; m_a = 0; m_b = 0; m_d = 0;
        end else begin
            int p;
            p     = m_phase;
            m_err = 1'b0;
            if (p == 3) m_count++;
            if (p == 0) begin
                if (cmd_valid) begin
                    m_op = cmd_op; m_ssel = cmd_scalar_sel; m_scal = cmd_scalar;
                    m_a = int'(cmd_src_a); m_b = int'(cmd_src_b); m_d = int'(cmd_dst);
                    if (m_a < NUM_VREGS && m_d < NUM_VREGS && (m_ssel || m_b < NUM_VREGS))
                        m_phase = 1;
                    else
                        m_err = 1'b1;
                end
            end else begin
                m_phase = (p == 3) ? 0 : p + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("alu_en", alu_en, m_phase == 2);
            chk("rf_wr_en", rf_wr_en, m_phase == 3);
            chk("done", done, m_phase == 3);
            chk("err", err, m_err);
            chk("op_count", op_count, m_count % (1 << CNT_W));
            chk("alu_op_sel", alu_op_sel, m_op);
            chk("alu_scalar_sel", alu_scalar_sel, m_ssel);
            chk("alu_scalar", alu_scalar, m_scal);
            if (m_phase != 0) begin
                chk("rf_rd_addr_a", rf_rd_addr_a, m_a);
                chk("rf_rd_addr_b", rf_rd_addr_b, m_b);
            end
            if (m_phase == 3) chk("rf_wr_addr", rf_wr_addr, m_d);
        end
    end

    task automatic drive(input logic [2:0] op, input logic ss, input logic [BITS-1:0] sc,
                         input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b,
                         input logic [IDX_W-1:0] d);
        cmd_op = op; cmd_scalar_sel = ss; cmd_scalar = sc;
        cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
        cmd_valid = 1'b1;
    endtask

    // Issue one command from an idle negedge and return at the idle negedge
    // after its write-back.
    task automatic run_cmd(input logic [2:0] op, input logic ss, input logic [BITS-1:0] sc,
                           input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b,
                           input logic [IDX_W-1:0] d);
        @(negedge clk);
        drive(op, ss, sc, a, b, d);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [2:0] ops [12];
        ops = '{3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd1, 3'd2, 3'd6, 3'd3, 3'd4, 3'd5, 3'd7};

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset alu_en", alu_en, 0);
        chk("reset rf_wr_en", rf_wr_en, 0);
        chk("reset op_count", op_count, 0);

        // Reset during EXEC abandons the instruction
        @(negedge clk);
        drive(3'b100, 1'b0, 8'h00, 4'd1, 4'd2, 4'd4);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset exec alu_en", alu_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst-exec rf_wr_en", rf_wr_en, 0);
        chk("rst-exec done", done, 0);
        chk("rst-exec busy", busy, 0);
        chk("rst-exec op_count", op_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst rf_wr_en", rf_wr_en, 0);

        // Single add with literal timing
        @(negedge clk);
        drive(3'b000, 1'b0, 8'h00, 4'd1, 4'd2, 4'd3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("add read addr_a", rf_rd_addr_a, 1);
        chk("add read addr_b", rf_rd_addr_b, 2);
        chk("add read cmd_ready", cmd_ready, 0);
        @(negedge clk);
        chk("add exec alu_en", alu_en, 1);
        chk("add exec op_sel", alu_op_sel, 0);
        @(negedge clk);
        chk("add write rf_wr_en", rf_wr_en, 1);
        chk("add write addr", rf_wr_addr, 3);
        chk("add write done", done, 1);
        @(negedge clk);
        chk("add op_count", op_count, 1);

        // Scalar multiply, src_b out of range but ignored
        @(negedge clk);
        drive(3'b010, 1'b1, 8'h05, 4'd2, 4'd15, 4'd6);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mul no err", err, 0);
        @(negedge clk);
        chk("mul scalar_sel", alu_scalar_sel, 1);
        chk("mul scalar", alu_scalar, 8'h05);
        @(negedge clk);
        chk("mul rf_wr_en", rf_wr_en, 1);
        @(negedge clk);
        chk("mul op_count", op_count, 2);

        // Illegal destination index
        @(negedge clk);
        drive(3'b001, 1'b0, 8'h00, 4'd1, 4'd2, 4'd9);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("illegal dst err", err, 1);
        chk("illegal dst busy", busy, 0);
        chk("illegal dst cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk("illegal dst err clears", err, 0);
        chk("illegal dst alu_en", alu_en, 0);
        chk("illegal dst op_count", op_count, 2);

        // Illegal src_a and illegal register-sourced src_b
        run_cmd(3'b000, 1'b0, 8'h00, 4'd8, 4'd0, 4'd0);
        run_cmd(3'b110, 1'b0, 8'h00, 4'd0, 4'd8, 4'd0);
        chk("illegal srcs op_count", op_count, 2);

        // Back-to-back: valid held, fields changed while busy
        @(negedge clk);
        drive(3'b001, 1'b0, 8'h00, 4'd3, 4'd4, 4'd3);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(3'b110, 1'b0, 8'h00, 4'd7, 4'd0, 4'd7);
            chk("b2b cmd_ready low", cmd_ready, 0);
        end
        @(negedge clk);
        chk("b2b cmd_ready high", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b second addr_a", rf_rd_addr_a, 7);
        repeat (3) @(negedge clk);
        chk("b2b op_count", op_count, 4);

        // Remaining ops, driving the counter through its wrap
        for (int i = 0; i < 12; i++) begin
            logic ss;
            ss = (i % 3 == 0);
            run_cmd(ops[i], ss, 8'(i * 17), 4'(i % 8),
                    ss ? 4'hC : 4'((i + 3) % 8), 4'((i * 5) % 8));
        end
        chk("wrap op_count", op_count, 0);
        run_cmd(3'b000, 1'b0, 8'h00, 4'd5, 4'd5, 4'd5);
        chk("after wrap op_count", op_count, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_alu_sequencer.md
Name: vector_alu_sequencer

Overview:
- Single-issue command sequencer that drives the vector element ALU datapath.
- Accepts one vector instruction per handshake (opcode, two source vector-register indices, optional scalar, destination index).
- Sequences the vector register file read, the ALU execute/capture and the register-file write-back.
- Sits between the host command interface and the vector register file / vector ALU pair; it is the only agent that raises the ALU enable.

Parameters:
BITS, 8, element width; width of scalar operand.
NUM_VREGS, 8, number of vector registers in the register file; valid indices 0..NUM_VREGS-1.
IDX_W, 4, width of register index fields; must satisfy 2**IDX_W >= NUM_VREGS. Indices >= NUM_VREGS are illegal.
CNT_W, 16, width of completed-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  3  ALU op select: 000 add, 001 sub, 010 mul, 011 cmp, 100 and, 101 or, 110 xor, 111 not.
cmd_scalar_sel  in  1  1 = B operand is cmd_scalar broadcast.
cmd_scalar  in  BITS  scalar operand.
cmd_src_a  in  IDX_W  source A register index.
cmd_src_b  in  IDX_W  source B register index (ignored when cmd_scalar_sel=1).
cmd_dst  in  IDX_W  destination register index.
rf_rd_addr_a  out  IDX_W  register-file read port A address.
rf_rd_addr_b  out  IDX_W  register-file read port B address.
alu_op_sel  out  3  to ALU op_sel.
alu_scalar_sel  out  1  to ALU scalar_sel.
alu_scalar  out  BITS  to ALU scalar.
alu_en  out  1  ALU result/length register capture enable.
rf_wr_en  out  1  register-file write strobe (writes ALU S and S_len).
rf_wr_addr  out  IDX_W  register-file write address.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse on successful write-back.
err  out  1  one-cycle pulse on rejected (illegal-index) command.
op_count  out  CNT_W  count of successfully completed instructions.

Behaviour:
- Reset (rst=1 on a clk edge): state=IDLE. All outputs 0 except cmd_ready=1. Latched command fields=0. op_count=0. Reset mid-instruction abandons it: no rf_wr_en, no done.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, scalar_sel, scalar, src_a, src_b, dst.
  - If any of src_a or dst >= NUM_VREGS, or src_b >= NUM_VREGS while scalar_sel=0: pulse err the next cycle and stay IDLE. Accepting a command this way consumes it.
  - Otherwise go to READ.
- READ (1 cycle):
  - rf_rd_addr_a/b = latched src_a/src_b. The register file has 1-cycle synchronous read latency.
  - cmd_ready=0. Go to EXEC.
- EXEC (1 cycle):
  - alu_en=1.
  - alu_op_sel, alu_scalar_sel, alu_scalar = latched values. The ALU registers capture on this edge.
  - Read addresses held. Go to WRITE.
- WRITE (1 cycle):
  - rf_wr_en=1, rf_wr_addr=latched dst, done=1.
  - op_count increments, wrapping from 2**CNT_W-1 to 0.
  - Go to IDLE.
- Latency and throughput: handshake edge to rf_wr_en is 3 cycles. Throughput is 1 instruction per 4 cycles. cmd_ready is deasserted in READ/EXEC/WRITE.
- ALU select signals hold their latched values from READ through WRITE. In IDLE they keep their last value; alu_en is 0 outside EXEC.
- dst equal to src_a or src_b is legal: the read completes before the write, so old values are used.
- err and done never assert in the same cycle. err does not change op_count.
- cmd_valid held high with a new command while busy: not accepted until the IDLE cycle after WRITE.
- cmd_* inputs are only sampled on the accepting edge; changes while busy have no effect.

Test Plan:
- Reset then idle: rst 2 cycles -> cmd_ready=1, busy=0, alu_en=0, rf_wr_en=0, op_count=0.
- Single add: op=000, src_a=1, src_b=2, dst=3, scalar_sel=0 -> rf_rd_addr_a=1/b=2 in READ; alu_en=1 with alu_op_sel=000 exactly 2 cycles after handshake; rf_wr_en=1, rf_wr_addr=3, done=1 at 3 cycles; op_count=1.
- Scalar multiply: op=010, scalar_sel=1, scalar=8'h05, src_b=15 (ignored) -> no err; alu_scalar_sel=1, alu_scalar=5 in EXEC; write-back completes.
- Illegal index: dst=9 with NUM_VREGS=8 -> err pulse 1 cycle, no alu_en, no rf_wr_en, op_count unchanged, cmd_ready back to 1.
- Back-to-back: cmd_valid held with two commands -> second accepted exactly 4 cycles after first; cmd_ready=0 for 3 cycles between; op_count=2.
- Reset in EXEC: assert rst during EXEC -> next cycle IDLE, no rf_wr_en or done, op_count unchanged.
